// File: rtl/ram_scan_ctrl_pkg.sv
// Shared types for the scanned display RAM controller.
package ram_scan_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    SHOW,
    WRITE,
    READ,
    WAIT
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_HOLD   = 2'b01;
  localparam logic [1:0] MODE_MANUAL = 2'b10;

endpackage

// File: rtl/ram_scan_ctrl_if.sv
// Switch-side write request and display-side read-out bundle of ram_scan_ctrl.
interface ram_scan_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              wr_ack;
  logic              busy;

  modport master (
    output wr_req, wr_addr, wr_data, mode, rd_addr,
    input  disp_addr, disp_data, disp_valid, wr_ack, busy
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, mode, rd_addr,
    output disp_addr, disp_data, disp_valid, wr_ack, busy
  );

endinterface

// File: rtl/ram_scan_ctrl_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, on the wrap cycle.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ram_scan_ctrl.sv
// Display RAM with a single switch-driven write port and an autonomous scan read-out.
//
// state | meaning
// CLEAR | power-up sweep writing zero to every word, busy high
// SHOW  | display stable, arbitrating pending write / tick / manual address
// WRITE | pending word written to RAM, wr_ack high
// READ  | rd_target presented to the RAM
// WAIT  | RAM output captured into the display registers
module ram_scan_ctrl
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int TICK_DIV = 50000000
) (
  input logic          CLOCK_50,
  input logic          reset,
  ram_scan_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t state;

  logic              tick;
  logic              req_s1, req_s2, req_d;
  logic              wr_pulse;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] scan_ptr;
  logic [ADDR_W-1:0] rd_target;

  logic [ADDR_W-1:0] disp_addr_r;
  logic [DATA_W-1:0] disp_data_r;
  logic              disp_valid_r;
  logic              wr_ack_r;
  logic              busy_r;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick)
  );

  // wr_req comes straight from a switch: synchronise before edge detection
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
      req_d  <= 1'b0;
    end else begin
      req_s1 <= bus.wr_req;
      req_s2 <= req_s1;
      req_d  <= req_s2;
    end
  end

  assign wr_pulse = req_s2 & ~req_d;

  always_comb begin
    ram_addr  = rd_target;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (state)
      CLEAR: begin
        ram_addr = clr_idx;
        ram_we   = 1'b1;
      end
      WRITE: begin
        ram_addr  = pend_addr;
        ram_wdata = pend_data;
        ram_we    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    q <= mem[ram_addr];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= CLEAR;
      clr_idx      <= '0;
      scan_ptr     <= '0;
      rd_target    <= '0;
      pend         <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= '0;
      disp_addr_r  <= '0;
      disp_data_r  <= '0;
      disp_valid_r <= 1'b0;
      wr_ack_r     <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      wr_ack_r <= 1'b0;
      // a new request always wins over the clear in WRITE so it is never lost
      if (wr_pulse) begin
        pend      <= 1'b1;
        pend_addr <= bus.wr_addr;
        pend_data <= bus.wr_data;
      end
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_ADDR) begin
            busy_r    <= 1'b0;
            rd_target <= scan_ptr;
            state     <= READ;
          end
        end
        SHOW: begin
          if (pend) begin
            wr_ack_r <= 1'b1;
            state    <= WRITE;
          end else if (bus.mode == MODE_AUTO && tick) begin
            scan_ptr  <= scan_ptr + 1'b1;
            rd_target <= scan_ptr + 1'b1;
            state     <= READ;
          end else if (bus.mode == MODE_MANUAL &&
                       (tick || bus.rd_addr != disp_addr_r)) begin
            rd_target <= bus.rd_addr;
            state     <= READ;
          end
        end
        WRITE: begin
          if (!wr_pulse) pend <= 1'b0;
          rd_target <= pend_addr;
          state     <= READ;
        end
        READ: state <= WAIT;
        WAIT: begin
          disp_addr_r  <= rd_target;
          disp_data_r  <= q;
          disp_valid_r <= 1'b1;
          state        <= SHOW;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.disp_addr  = disp_addr_r;
  assign bus.disp_data  = disp_data_r;
  assign bus.disp_valid = disp_valid_r;
  assign bus.wr_ack     = wr_ack_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Directed bench for ram_scan_ctrl with TICK_DIV=4, 32x8 RAM.
module tb_ram_scan_ctrl;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   n_tests  = 0;
  int   n_fail   = 0;

  ram_scan_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  ram_scan_ctrl #(.ADDR_W(5), .DATA_W(8), .TICK_DIV(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_addr(input logic [4:0] target, input int max_cyc, output int n, output bit ok);
    n  = 0;
    ok = (bus.disp_addr == target);
    while (!ok && n < max_cyc) begin
      step();
      n++;
      ok = (bus.disp_addr == target);
    end
  endtask

  task automatic wait_change(input int max_cyc, output int n, output bit ok);
    logic [4:0] start;
    start = bus.disp_addr;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < max_cyc) begin
      step();
      n++;
      ok = (bus.disp_addr != start);
    end
  endtask

  // raises wr_req and returns edges until wr_ack is seen; wr_req stays high
  task automatic raise_write(input logic [4:0] a, input logic [7:0] d, output int n, output bit ok);
    @(negedge CLOCK_50);
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 60) begin
      step();
      n++;
      ok = bus.wr_ack;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         acks;
    bit         ok;
    bit         ack_in_busy;
    logic [4:0] exp_a;

    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.mode    = 2'b00;
    bus.rd_addr = '0;

    step();
    step();
    check("rst_busy",  32'(bus.busy), 32'h1);
    check("rst_valid", 32'(bus.disp_valid), 32'h0);
    check("rst_addr",  32'(bus.disp_addr), 32'h0);
    check("rst_data",  32'(bus.disp_data), 32'h0);
    check("rst_ack",   32'(bus.wr_ack), 32'h0);

    @(negedge CLOCK_50);
    reset = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.busy && n < 100);
    check("clear_cycles", 32'(n), 32'd32);
    wait_addr(5'h00, 10, n, ok);
    n = 0;
    while (!bus.disp_valid && n < 10) begin
      step();
      n++;
    end
    check("post_clear_valid", 32'(bus.disp_valid), 32'h1);
    check("post_clear_addr",  32'(bus.disp_addr), 32'h0);
    check("post_clear_data",  32'(bus.disp_data), 32'h0);

    // AUTO scan: 33 steps covers the 0x1F -> 0x00 wrap
    exp_a = 5'h00;
    for (int i = 0; i < 33; i++) begin
      exp_a = exp_a + 5'd1;
      wait_change(20, n, ok);
      check("auto_step_ok",   32'(ok), 32'h1);
      check("auto_step_addr", 32'(bus.disp_addr), 32'(exp_a));
      check("auto_step_data", 32'(bus.disp_data), 32'h0);
      if (i > 0) check("auto_step_period", 32'(n), 32'd4);
    end
    wait_addr(5'h03, 20, n, ok);
    check("auto_reach3", 32'(ok), 32'h1);
    @(negedge CLOCK_50);
    bus.mode = 2'b01;
    repeat (6) step();
    check("hold_ptr", 32'(bus.disp_addr), 32'h03);

    // single write, request held high for 100 cycles
    raise_write(5'h05, 8'hA7, n, ok);
    check("wr_ack_seen", 32'(ok), 32'h1);
    check("wr_ack_latency_3to4", 32'(n >= 3 && n <= 4), 32'h1);
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.wr_ack) acks++;
      if (i == 2) begin
        check("wr_disp_addr", 32'(bus.disp_addr), 32'h05);
        check("wr_disp_data", 32'(bus.disp_data), 32'hA7);
      end
    end
    check("held_req_no_extra_ack", 32'(acks), 32'h0);
    check("hold_freeze_addr", 32'(bus.disp_addr), 32'h05);
    check("hold_freeze_data", 32'(bus.disp_data), 32'hA7);
    bus.wr_req = 1'b0;
    repeat (3) step();

    raise_write(5'h06, 8'h11, n, ok);
    check("wr6_ack_seen", 32'(ok), 32'h1);
    repeat (3) step();
    check("wr6_disp_addr", 32'(bus.disp_addr), 32'h06);
    check("wr6_disp_data", 32'(bus.disp_data), 32'h11);
    bus.wr_req = 1'b0;

    // MANUAL
    @(negedge CLOCK_50);
    bus.rd_addr = 5'h05;
    bus.mode    = 2'b10;
    wait_addr(5'h05, 10, n, ok);
    check("man5_ok",   32'(ok), 32'h1);
    check("man5_data", 32'(bus.disp_data), 32'hA7);
    @(negedge CLOCK_50);
    bus.mode = 2'b01;
    repeat (4) step();
    @(negedge CLOCK_50);
    bus.rd_addr = 5'h06;
    bus.mode    = 2'b10;
    wait_addr(5'h06, 10, n, ok);
    check("man6_ok",      32'(ok), 32'h1);
    check("man6_latency", 32'(n), 32'd3);
    check("man6_data",    32'(bus.disp_data), 32'h11);

    // back to AUTO resumes from scan pointer 0x03
    @(negedge CLOCK_50);
    bus.mode = 2'b00;
    wait_change(12, n, ok);
    check("resume_ok",   32'(ok), 32'h1);
    check("resume_addr", 32'(bus.disp_addr), 32'h04);
    check("resume_data", 32'(bus.disp_data), 32'h00);

    // reset while the WRITE is in progress
    @(negedge CLOCK_50);
    bus.mode = 2'b01;
    repeat (4) step();
    raise_write(5'h07, 8'h77, n, ok);
    check("midwr_ack_seen", 32'(ok), 32'h1);
    reset      = 1'b1;
    bus.wr_req = 1'b0;
    #1;
    check("midwr_rst_busy",  32'(bus.busy), 32'h1);
    check("midwr_rst_valid", 32'(bus.disp_valid), 32'h0);
    check("midwr_rst_addr",  32'(bus.disp_addr), 32'h0);
    check("midwr_rst_data",  32'(bus.disp_data), 32'h0);
    check("midwr_rst_ack",   32'(bus.wr_ack), 32'h0);
    repeat (2) step();
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (5) step();
    check("clr_busy_before_req", 32'(bus.busy), 32'h1);
    ack_in_busy = 1'b0;
    @(negedge CLOCK_50);
    bus.wr_addr = 5'h02;
    bus.wr_data = 8'h3C;
    bus.wr_req  = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 80) begin
      step();
      n++;
      ok = bus.wr_ack;
      if (bus.wr_ack && bus.busy) ack_in_busy = 1'b1;
    end
    check("clr_wr_ack_seen",   32'(ok), 32'h1);
    check("clr_wr_not_in_busy", 32'(ack_in_busy), 32'h0);
    repeat (3) step();
    check("clr_wr_disp_addr", 32'(bus.disp_addr), 32'h02);
    check("clr_wr_disp_data", 32'(bus.disp_data), 32'h3C);
    bus.wr_req = 1'b0;

    // MANUAL sweep: everything cleared except the deferred write
    @(negedge CLOCK_50);
    bus.mode = 2'b10;
    for (int a = 0; a < 32; a++) begin
      @(negedge CLOCK_50);
      bus.rd_addr = 5'(a);
      wait_addr(5'(a), 12, n, ok);
      check("sweep_ok",   32'(ok), 32'h1);
      check("sweep_data", 32'(bus.disp_data), (a == 2) ? 32'h3C : 32'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_scan_ctrl.md
Name: ram_scan_ctrl

Overview:
- Parametrised on-chip RAM with a single user write port and an autonomous display read-out path.
- Successor to the board-level 32x8 switch-written RAM demo. Adds:
  - configurable width and depth
  - inferred RAM instead of a vendor megafunction
  - power-up clear sweep
  - synchronised write-request edge detection
  - three read modes (auto-scan, hold, manual)
  - explicit busy/ack/valid handshake signals
- Sits between board switches and the HEX/LED display decoders. Display decoders consume disp_addr/disp_data.

Parameters:
- ADDR_W, 5, address width; depth = 2**ADDR_W words.
- DATA_W, 8, word width.
- TICK_DIV, 50000000, CLOCK_50 cycles per scan tick (1 Hz at 50 MHz); must be >= 4.

Ports:
- CLOCK_50 in 1 — sole clock, all logic on rising edge.
- reset in 1 — asynchronous, active-high reset.
- wr_req in 1 — asynchronous level request (switch); a rising edge requests one write.
- wr_addr in ADDR_W — write address, sampled on detected edge.
- wr_data in DATA_W — write data, sampled on detected edge.
- mode in 2 — 00 AUTO scan, 01 HOLD, 10 MANUAL, 11 treated as HOLD.
- rd_addr in ADDR_W — read address used in MANUAL mode.
- disp_addr out ADDR_W — address of the word currently displayed.
- disp_data out DATA_W — RAM contents at disp_addr.
- disp_valid out 1 — high once the first post-clear read has completed.
- wr_ack out 1 — one-cycle pulse in the cycle the RAM write occurs.
- busy out 1 — high during the CLEAR sweep.

Behaviour:
- Reset, asynchronous:
  - disp_addr=0, disp_data=0, disp_valid=0, wr_ack=0, busy=1.
  - scan pointer=0, tick counter=0, synchroniser and edge flops=0, pending flag=0.
  - state=CLEAR, clear index=0.
- Reset asserted mid-operation aborts any write or read immediately. RAM contents are not preserved; they are re-cleared.
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick is a one-cycle pulse on the wrap cycle. Free-running in all states, including CLEAR.
- Write-request path:
  - wr_req passes a 2-flop synchroniser, then a rising-edge detector, producing wr_pulse.
  - On wr_pulse, wr_addr/wr_data are captured into a pending register and pending=1.
  - A second wr_pulse while pending is set overwrites the captured values (last request wins).
  - A held-high wr_req produces exactly one write.
- RAM: single-port inferred, synchronous read with 1-cycle latency, write-first is not required.
- FSM states:
  - CLEAR: write 0 to ram[clear index] each cycle, then increment. After address 2**ADDR_W-1, go to READ at the scan pointer. busy=1 only in this state. Duration is 2**ADDR_W cycles. A wr_pulse during CLEAR is held pending.
  - SHOW: idle while displaying. Priority order:
    1. pending → WRITE.
    2. AUTO and tick → pointer+1 (wraps 2**ADDR_W-1→0), then READ.
    3. MANUAL and (tick or rd_addr differs from disp_addr) → READ at rd_addr.
    4. HOLD: no action.
  - WRITE: ram[pending addr]<=pending data, wr_ack=1, pending=0, then READ at the written address. Scan pointer is unchanged.
  - READ: present the read address (registered as rd_target). Go to WAIT.
  - WAIT: RAM output valid. disp_addr<=rd_target, disp_data<=q, disp_valid<=1, then SHOW.
- Latency:
  - A tick in SHOW updates the display outputs 3 cycles later.
  - wr_req rise to wr_ack is 3–4 cycles when idle.
  - wr_ack to display of the written word is 3 cycles.
- Simultaneous wr_pulse and tick: the write is serviced first. In AUTO the tick is dropped, not queued.
- Ticks arriving in non-SHOW states are ignored.
- Mode changes take effect on the next SHOW evaluation.
- Leaving MANUAL for AUTO resumes from the retained scan pointer, not from rd_addr.

Decomposition:
- Package ram_scan_pkg: state enum (CLEAR, SHOW, WRITE, READ, WAIT), mode constants MODE_AUTO/MODE_HOLD/MODE_MANUAL.
- Sub-module tick_gen (parameter TICK_DIV; ports CLOCK_50, reset, tick). Reusable by other lab blocks.
- RAM inferred inside ram_scan_ctrl as its own always block.

Test Plan:
- Reset, TICK_DIV=4, ADDR_W=5: busy=1 for 32 cycles, then disp_valid=1, disp_addr=0x00, disp_data=0x00.
- AUTO after clear: disp_addr steps 0x00,0x01,… once per 4 cycles and wraps 0x1F→0x00; disp_data stays 0x00.
- wr_req rise with wr_addr=0x05, wr_data=0xA7: exactly one wr_ack; 3 cycles later disp_addr=0x05, disp_data=0xA7; wr_req held high 100 cycles gives no further wr_ack.
- wr_req rise during CLEAR (addr 0x02, data 0x3C): write deferred until busy falls; wr_ack follows; later read of 0x02 returns 0x3C, not 0x00.
- MANUAL, rd_addr 0x05→0x06 after writing 0x06=0x11: display shows 0x06/0x11 within 3 cycles of the change; HOLD freezes disp_addr across 10 ticks.
- Reset asserted mid-WRITE: outputs return to reset values immediately; after the new clear, all addresses read 0x00.
